// File: rtl/pc_load_ctrl.sv
// pc_load_ctrl: control stage for a 16-bit program counter made of four
// cascaded '163 counters. Drives the chain's synchronous clear, parallel
// enable, count enable and load data. Jump targets are assembled from two
// bus bytes, and jumps are qualified by a condition selected from the CPU flags.
// Every output is a flop loaded from the next state, so no input reaches an
// output through combinational logic.
module pc_load_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int ADDR_W       = 16
) (
    input  logic              CP,
    input  logic              _MR,
    input  logic [7:0]        BUS,
    input  logic              _LDLO,
    input  logic              _LDHI,
    input  logic              JMP,
    input  logic [2:0]        COND_SEL,
    input  logic [3:0]        FLAGS,
    input  logic              HALT,
    input  logic              RUN,
    output logic              _PC_MR,
    output logic              _PC_PE,
    output logic              PC_CEP,
    output logic [ADDR_W-1:0] PC_D,
    output logic              TAKEN,
    output logic              HALTED
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOAD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       cond_ok;
    logic       taken_now;
    logic [7:0] hi_eff;
    logic [7:0] lo_eff;

    // Evaluate the jump condition and the target with same-edge byte bypass
    always_comb begin
        cond_ok = 1'b0;
        case (COND_SEL)
            3'd0:    cond_ok = 1'b1;
            3'd1:    cond_ok = FLAGS[0];
            3'd2:    cond_ok = FLAGS[1];
            3'd3:    cond_ok = FLAGS[2];
            3'd4:    cond_ok = FLAGS[3];
            default: cond_ok = 1'b0;
        endcase
        taken_now = JMP & cond_ok;
        hi_eff    = (_LDHI == 1'b0) ? BUS : hi;
        lo_eff    = (_LDLO == 1'b0) ? BUS : lo;
    end

    // Next-state selection; a taken jump beats HALT, and HALT beats RUN
    always_comb begin
        state_next = state;
        case (state)
            ST_RST: begin
                // The edge where the counter reads 1 is the last clearing edge
                if (cnt <= 4'd1)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (taken_now)
                    state_next = ST_LOAD;
                else if (HALT)
                    state_next = ST_HALTED;
            end
            ST_LOAD: begin
                // Exactly one load cycle; a JMP seen here cannot retarget
                state_next = HALT ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                if (taken_now)
                    state_next = ST_LOAD;
                else if (RUN && !HALT)
                    state_next = ST_RUN;
            end
            default: state_next = ST_RST;
        endcase
    end

    // Target byte registers follow their strobes in every state
    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            hi <= 8'h00;
            lo <= 8'h00;
        end else begin
            if (!_LDHI)
                hi <= BUS;
            if (!_LDLO)
                lo <= BUS;
        end
    end

    // State, reset-cycle counter, target and registered outputs
    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            state  <= ST_RST;
            cnt    <= 4'(RESET_CYCLES);
            PC_D   <= '0;
            _PC_MR <= 1'b0;
            _PC_PE <= 1'b1;
            PC_CEP <= 1'b0;
            TAKEN  <= 1'b0;
            HALTED <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_RST && cnt > 4'd1)
                cnt <= cnt - 4'd1;
            // The target only changes on an edge that actually enters LOAD
            if ((state == ST_RUN || state == ST_HALTED) && taken_now)
                PC_D <= ADDR_W'({hi_eff, lo_eff});
            _PC_MR <= (state_next != ST_RST);
            _PC_PE <= (state_next != ST_LOAD);
            PC_CEP <= (state_next == ST_RUN);
            TAKEN  <= (state_next == ST_LOAD);
            HALTED <= (state_next == ST_HALTED);
        end
    end

endmodule

// File: doc/pc_load_ctrl.md
Name: pc_load_ctrl

Overview:
- Control stage directly upstream of the 16-bit program counter built from four cascaded hct74163 counters sharing CP.
- Generates the counter chain's synchronous clear, parallel-enable, count-enable and 16-bit load data.
- Assembles jump targets from an 8-bit bus in two byte loads and evaluates the jump condition against CPU flags.
- Converts the system's asynchronous reset into the multi-cycle synchronous clear the '163 chain requires.

Parameters:
RESET_CYCLES, 2, number of CP edges _PC_MR is held low after _MR deasserts (1..15).
ADDR_W, 16, target/PC width; fixed at 16 (two bus bytes); other values unsupported.

Ports:
CP  input  1  clock, rising edge, same clock as the PC counter chain
_MR  input  1  reset, asynchronous, active-low
BUS  input  8  data bus carrying target bytes
_LDLO  input  1  active-low; latch BUS into low target byte at CP edge
_LDHI  input  1  active-low; latch BUS into high target byte at CP edge
JMP  input  1  jump request, sampled at CP edge
COND_SEL  input  3  0=always; 1..4=FLAGS[COND_SEL-1]; 5..7=never
FLAGS  input  4  CPU condition flags
HALT  input  1  level halt request
RUN  input  1  resume request
_PC_MR  output  1  to counter _MR (synchronous clear), active-low
_PC_PE  output  1  to counter _PE, active-low
PC_CEP  output  1  to counter CEP (chain CET handled by cascade)
PC_D  output  16  to counter D inputs
TAKEN  output  1  high during LOAD state
HALTED  output  1  high in HALTED state

Behaviour:
- States: RST, RUN, LOAD, HALTED. All outputs decoded from registered state only (no input-to-output combinational paths).
- _MR low (async, any state): state=RST, cycle counter=RESET_CYCLES, hi/lo bytes=0, target reg=0.
  Outputs: _PC_MR=0, _PC_PE=1, PC_CEP=0, PC_D=0, TAKEN=0, HALTED=0.
- RST: _PC_MR=0. Counter decrements each edge; the edge where it is 1 moves to RUN. JMP/HALT/RUN ignored. _LDLO/_LDHI honoured.
- RUN: PC_CEP=1, _PC_PE=1, _PC_MR=1.
- Jump taken = JMP & cond(COND_SEL, FLAGS), evaluated at the edge.
- Target captured on a taken edge = {(_LDHI==0 ? BUS : hi), (_LDLO==0 ? BUS : lo)}, i.e. same-edge byte loads bypass into the target. Both strobes low loads BUS into both bytes.
- RUN transitions at edge:
  - taken jump -> LOAD (priority over HALT);
  - else HALT -> HALTED;
  - else stay.
- LOAD: exactly one cycle. _PC_PE=0, PC_CEP=0, PC_D=target, TAKEN=1. Counters load at the exiting edge.
  - Next edge -> HALTED if HALT=1, else RUN.
  - JMP during LOAD ignored (no back-to-back retarget).
- Latency: taken JMP sampled at edge n -> counter chain Q = target after edge n+1. PC does not increment at edge n+1.
- HALTED: PC_CEP=0, HALTED=1.
  - Taken jump -> LOAD (front-panel load while halted).
  - Else RUN=1 and HALT=0 -> RUN.
  - HALT=1 always keeps HALTED (halt beats RUN).
- hi/lo byte registers update on their strobes in every state except during _MR low.
- Not-taken jump (cond false or COND_SEL 5..7): no state change, PC keeps counting. Bytes still latched if strobed.
- PC_D holds the last target outside LOAD. It is don't-care to the counters since _PC_PE=1.
- Reset asserted mid-LOAD: immediate RST. _PC_PE returns high asynchronously; no load occurs.

Test Plan:
1. _MR low 3 cycles, release, RESET_CYCLES=2 -> _PC_MR low for exactly 2 edges after release; PC_CEP rises with RUN; chain counts 0,1,2...
2. RUN, _LDHI with BUS=8'h12, then _LDLO with BUS=8'h34, then JMP with COND_SEL=0 at edge n -> TAKEN/_PC_PE low one cycle, PC_D=16'h1234, PC=16'h1234 after edge n+1, then 16'h1235.
3. Same edge: _LDLO low BUS=8'hAB, JMP, hi=8'h00 -> target 16'h00AB (bypass). Then COND_SEL=2, FLAGS=4'b0000 -> no jump, PC increments. Then FLAGS=4'b0010 -> jump. COND_SEL=6 -> never.
4. HALT and taken JMP same edge -> LOAD then HALTED (HALT still high), PC frozen at target. RUN with HALT=0 -> counting resumes. RUN with HALT=1 -> stays HALTED.
5. Counter at 16'hFFFF in RUN -> wraps to 16'h0000; block ignores wrap (no state change).
6. _MR asserted during LOAD -> _PC_PE=1 and _PC_MR=0 immediately; next edges clear PC to 0, no load of target.
